// File: rtl/exp_result_sink.sv
// exp_result_sink
// Output-side endpoint of the exponential pipeline. Each result strobed by the
// stage controller is captured into a small FIFO and presented downstream on a
// valid/ack handshake. An issue credit keeps the input side from launching a
// conversion whose result would have nowhere to go.
//
// Ports:
//   CLK          clock, rising edge
//   rst          synchronous active-high reset (control state only)
//   issue        pulse: input side launched a conversion
//   result_valid pulse: result_data is valid
//   result_data  pipeline result
//   issue_ok     credit available (buffered + in-flight < DEPTH)
//   out_valid    FIFO non-empty
//   out_data     head entry, 0 when empty
//   out_ack      downstream consumes the head this cycle
//   d_count      FIFO occupancy
//   d_err        sticky errors: [0] overflow, [1] spurious result / issue without credit
module exp_result_sink #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              issue,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_data,
  output logic              issue_ok,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  output logic [AW:0]       d_count,
  output logic [1:0]        d_err
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  // One extra bit so count + inflight (each up to DEPTH) cannot wrap.
  localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]   count_q, count_d;
  logic [AW:0]   inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]    err_q, err_d;

  logic          rd_en;
  logic          wr_en;
  logic          issue_acc;
  logic          inflight_dec;
  logic [AW+1:0] occupancy;

  always_comb begin
    rd_en        = out_ack && (count_q != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    wr_en        = result_valid && ((count_q < DEPTH_C) || rd_en);
    occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
    issue_ok     = occupancy < DEPTH_X;
    issue_acc    = issue && issue_ok;
    // A spurious result (nothing in flight) must not underflow the counter.
    inflight_dec = result_valid && (inflight_q != '0);

    count_d    = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    inflight_d = inflight_q + (AW+1)'(issue_acc) - (AW+1)'(inflight_dec);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;

    err_d      = err_q;
    err_d[0]   = err_q[0] | (result_valid && !wr_en);
    err_d[1]   = err_q[1] | (issue && !issue_ok) | (result_valid && (inflight_q == '0));
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  // Storage is data-only and never reset; the reset pointers make stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (!rst && wr_en) begin
      mem[wr_ptr_q] <= result_data;
    end
  end

  assign out_valid = count_q != '0;
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign d_count   = count_q;
  assign d_err     = err_q;

endmodule

// File: tb/tb_exp_result_sink.sv
module tb_exp_result_sink;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic              issue = 1'b0;
  logic              result_valid = 1'b0;
  logic [DATA_W-1:0] result_data = '0;
  logic              issue_ok;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ack = 1'b0;
  logic [AW:0]       d_count;
  logic [1:0]        d_err;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] sb_q[$];

  exp_result_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .rst(rst), .issue(issue), .result_valid(result_valid),
    .result_data(result_data), .issue_ok(issue_ok), .out_valid(out_valid),
    .out_data(out_data), .out_ack(out_ack), .d_count(d_count), .d_err(d_err)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: on every consuming handshake the head must match the oldest expected entry.
  always @(negedge CLK) begin
    if (!rst && out_valid && out_ack) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected out_data=%h with empty scoreboard", out_data);
      end else begin
        logic [DATA_W-1:0] exp_v;
        exp_v = sb_q.pop_front();
        if (out_data !== exp_v) begin
          errors++;
          $display("FAIL sb_data got=%h exp=%h", out_data, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; issue = 1'b0; result_valid = 1'b0; out_ack = 1'b0; result_data = '0;
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic send_issue();
    issue = 1'b1;
    tick();
    issue = 1'b0;
  endtask

  task automatic send_result(input logic [DATA_W-1:0] v, input bit expect_kept);
    result_valid = 1'b1;
    result_data  = v;
    if (expect_kept) sb_q.push_back(v);
    tick();
    result_valid = 1'b0;
    result_data  = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL reset_out got valid=%b data=%h exp 0/0", out_valid, out_data);
    end
    checks++;
    if (issue_ok !== 1'b1 || d_err !== 2'b00 || d_count !== 3'd0) begin
      errors++; $display("FAIL reset_ctrl got ok=%b err=%b cnt=%0d exp 1/00/0", issue_ok, d_err, d_count);
    end
    for (int i = 0; i < 3; i++) begin
      out_ack = 1'b1; tick(); out_ack = 1'b0; tick();
    end
    checks++;
    if (d_count !== 3'd0 || out_valid !== 1'b0 || d_err !== 2'b00) begin
      errors++; $display("FAIL idle_ack got cnt=%0d valid=%b err=%b exp 0/0/00", d_count, out_valid, d_err);
    end
  endtask

  task automatic test_single_flow();
    do_reset();
    send_issue();
    tick(); tick(); tick();
    out_ack = 1'b1;
    send_result(32'h3F80_0000, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h3F80_0000) begin
      errors++; $display("FAIL single_out got valid=%b data=%h exp 1/3f800000", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || d_count !== 3'd0 || d_err !== 2'b00) begin
      errors++; $display("FAIL single_drain got valid=%b cnt=%0d err=%b exp 0/0/00", out_valid, d_count, d_err);
    end
    out_ack = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) send_issue();
    checks++;
    if (issue_ok !== 1'b1) begin
      errors++; $display("FAIL bp_ok3 got=%b exp=1", issue_ok);
    end
    send_issue();
    checks++;
    if (issue_ok !== 1'b0 || d_err !== 2'b00) begin
      errors++; $display("FAIL bp_ok4 got ok=%b err=%b exp 0/00", issue_ok, d_err);
    end
    send_issue();
    checks++;
    if (d_err !== 2'b10) begin
      errors++; $display("FAIL bp_noissue_err got=%b exp=10", d_err);
    end
    for (int i = 1; i <= 4; i++) begin
      send_result(DATA_W'(i), 1'b1);
      tick(); tick(); tick();
    end
    checks++;
    if (d_count !== 3'd4 || issue_ok !== 1'b0 || out_data !== 32'd1) begin
      errors++; $display("FAIL bp_full got cnt=%0d ok=%b head=%h exp 4/0/1", d_count, issue_ok, out_data);
    end
    out_ack = 1'b1; tick(); out_ack = 1'b0;
    checks++;
    if (issue_ok !== 1'b1 || d_count !== 3'd3) begin
      errors++; $display("FAIL bp_ack1 got ok=%b cnt=%0d exp 1/3", issue_ok, d_count);
    end
    out_ack = 1'b1; tick(); tick(); tick(); out_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++; $display("FAIL bp_drain got valid=%b pending=%0d exp 0/0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_full_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) send_issue();
    for (int i = 0; i < 4; i++) send_result(32'h10 + DATA_W'(i), 1'b1);
    out_ack = 1'b1;
    send_result(32'hAA, 1'b1);
    out_ack = 1'b0;
    checks++;
    if (d_err[0] !== 1'b0 || d_count !== 3'd4) begin
      errors++; $display("FAIL full_simul got ovf=%b cnt=%0d exp 0/4", d_err[0], d_count);
    end
    send_result(32'hBB, 1'b0);
    checks++;
    if (d_err[0] !== 1'b1 || d_count !== 3'd4) begin
      errors++; $display("FAIL full_drop got ovf=%b cnt=%0d exp 1/4", d_err[0], d_count);
    end
    out_ack = 1'b1; tick(); tick(); tick(); tick(); out_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++; $display("FAIL full_drain got valid=%b pending=%0d exp 0/0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_spurious();
    do_reset();
    send_result(32'h55, 1'b1);
    checks++;
    if (d_err !== 2'b10 || d_count !== 3'd1 || out_data !== 32'h55) begin
      errors++; $display("FAIL spur got err=%b cnt=%0d data=%h exp 10/1/55", d_err, d_count, out_data);
    end
    send_issue(); send_issue();
    checks++;
    if (issue_ok !== 1'b1) begin
      errors++; $display("FAIL spur_inflight2 got ok=%b exp=1", issue_ok);
    end
    send_issue();
    checks++;
    if (issue_ok !== 1'b0) begin
      errors++; $display("FAIL spur_inflight3 got ok=%b exp=0", issue_ok);
    end
    out_ack = 1'b1; tick(); out_ack = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 4; i++) send_issue();
    for (int i = 0; i < 3; i++) send_result(32'h21 + DATA_W'(i), 1'b1);
    send_issue();
    checks++;
    if (d_count !== 3'd3 || issue_ok !== 1'b0 || d_err !== 2'b10) begin
      errors++; $display("FAIL mid_pre got cnt=%0d ok=%b err=%b exp 3/0/10", d_count, issue_ok, d_err);
    end
    // Reset while every other input is active: reset must win.
    rst = 1'b1; issue = 1'b1; result_valid = 1'b1; result_data = 32'h99; out_ack = 1'b1;
    tick();
    rst = 1'b0; issue = 1'b0; result_valid = 1'b0; result_data = '0; out_ack = 1'b0;
    sb_q.delete();
    checks++;
    if (d_count !== 3'd0 || issue_ok !== 1'b1 || d_err !== 2'b00 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst got cnt=%0d ok=%b err=%b valid=%b exp 0/1/00/0", d_count, issue_ok, d_err, out_valid);
    end
    for (int i = 0; i < 3; i++) send_issue();
    for (int i = 0; i < 3; i++) send_result(32'hC0 + DATA_W'(i), 1'b1);
    out_ack = 1'b1; tick(); tick(); tick(); out_ack = 1'b0;
    for (int i = 0; i < 3; i++) send_issue();
    for (int i = 0; i < 3; i++) send_result(32'hD0 + DATA_W'(i), 1'b1);
    checks++;
    if (d_count !== 3'd3 || out_data !== 32'hD0 || d_err !== 2'b00) begin
      errors++; $display("FAIL wrap_head got cnt=%0d head=%h err=%b exp 3/d0/00", d_count, out_data, d_err);
    end
    out_ack = 1'b1; tick(); tick(); tick(); out_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++; $display("FAIL wrap_drain got valid=%b pending=%0d exp 0/0", out_valid, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_flow();
    test_backpressure();
    test_full_simultaneous();
    test_spurious();
    test_reset_midstream();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
